// File: rtl/ballot_controller.sv
// Ballot controller: arms one ballot per officer request, debounces the
// voter's press, records exactly one vote and handles poll closing.
module ballot_controller #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ballot_req,
  input  logic       poll_close,
  input  logic [2:0] vswitch,
  output logic       vote_en,
  output logic [2:0] vote_sel,
  output logic       ballot_ready,
  output logic       inv,
  output logic       timeout,
  output logic       poll_closed,
  output logic [7:0] votes_cast,
  output logic [2:0] state
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CONFIRM = 3'd2,
    RECORD  = 3'd3,
    RELEASE = 3'd4,
    CLOSED  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          pend_q, pend_d;
  logic          vote_en_q, vote_en_d;
  logic [2:0]    vote_sel_q, vote_sel_d;
  logic          ready_q, ready_d;
  logic          inv_q, inv_d;
  logic          to_q, to_d;
  logic          closed_q, closed_d;
  logic [7:0]    votes_q, votes_d;

  logic   onehot;
  state_t idle_tgt;

  assign onehot = (vswitch == 3'b001) || (vswitch == 3'b010) ||
                  (vswitch == 3'b100);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    tcnt_d   = tcnt_q;
    pend_d   = pend_q;
    inv_d    = 1'b0;
    to_d     = 1'b0;
    votes_d  = votes_q;
    // a close seen this cycle redirects the return to IDLE immediately
    idle_tgt = (pend_q || poll_close) ? CLOSED : IDLE;

    if (poll_close && state_q != IDLE && state_q != CLOSED)
      pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (poll_close || pend_q) begin
          state_d = CLOSED;
        end else if (ballot_req) begin
          state_d = ARMED;
          tcnt_d  = '0;
        end
      end
      ARMED: begin
        if (onehot) begin
          sel_d   = vswitch;
          cnt_d   = CW'(1);
          state_d = (DEBOUNCE == 1) ? RECORD : CONFIRM;
        end else if (vswitch == 3'b000) begin
          if (tcnt_q == TO_LAST) begin
            to_d    = 1'b1;
            state_d = idle_tgt;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end else begin
          inv_d = 1'b1;
          if (tcnt_q != TO_LAST)
            tcnt_d = tcnt_q + TW'(1);
        end
      end
      CONFIRM: begin
        if (vswitch == sel_q) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == DB_LAST)
            state_d = RECORD;
        end else if (vswitch == 3'b000) begin
          state_d = ARMED;
        end else begin
          inv_d   = 1'b1;
          state_d = ARMED;
        end
      end
      RECORD:  state_d = RELEASE;
      RELEASE: if (vswitch == 3'b000) state_d = idle_tgt;
      CLOSED:  state_d = CLOSED;
      default: state_d = IDLE;
    endcase

    if (state_d == RECORD && votes_q != 8'hff)
      votes_d = votes_q + 8'd1;

    vote_en_d  = (state_d == RECORD);
    vote_sel_d = vote_en_d ? sel_d : 3'b000;
    ready_d    = (state_d == ARMED) || (state_d == CONFIRM);
    closed_d   = (state_d == CLOSED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      tcnt_q     <= '0;
      pend_q     <= 1'b0;
      vote_en_q  <= 1'b0;
      vote_sel_q <= '0;
      ready_q    <= 1'b0;
      inv_q      <= 1'b0;
      to_q       <= 1'b0;
      closed_q   <= 1'b0;
      votes_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      tcnt_q     <= tcnt_d;
      pend_q     <= pend_d;
      vote_en_q  <= vote_en_d;
      vote_sel_q <= vote_sel_d;
      ready_q    <= ready_d;
      inv_q      <= inv_d;
      to_q       <= to_d;
      closed_q   <= closed_d;
      votes_q    <= votes_d;
    end
  end

  assign vote_en      = vote_en_q;
  assign vote_sel     = vote_sel_q;
  assign ballot_ready = ready_q;
  assign inv          = inv_q;
  assign timeout      = to_q;
  assign poll_closed  = closed_q;
  assign votes_cast   = votes_q;
  assign state        = state_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller with DEBOUNCE=2, TIMEOUT=8.
module tb_ballot_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ballot_req = 1'b0;
  logic       poll_close = 1'b0;
  logic [2:0] vswitch = 3'b000;
  logic       vote_en;
  logic [2:0] vote_sel;
  logic       ballot_ready;
  logic       inv;
  logic       timeout;
  logic       poll_closed;
  logic [7:0] votes_cast;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;
  int n_ev;

  ballot_controller #(.DEBOUNCE(2), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ballot_req   (ballot_req),
    .poll_close   (poll_close),
    .vswitch      (vswitch),
    .vote_en      (vote_en),
    .vote_sel     (vote_sel),
    .ballot_ready (ballot_ready),
    .inv          (inv),
    .timeout      (timeout),
    .poll_closed  (poll_closed),
    .votes_cast   (votes_cast),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic one_ballot();
    ballot_req = 1'b1; tick();
    ballot_req = 1'b0; vswitch = 3'b001; tick();
    tick();
    tick();
    vswitch = 3'b000; tick();
  endtask

  initial begin
    // reset
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_votes", 32'(votes_cast), 32'd0);
    chk("rst_vote_en", 32'(vote_en), 32'd0);
    chk("rst_ready", 32'(ballot_ready), 32'd0);
    chk("rst_closed", 32'(poll_closed), 32'd0);

    // normal vote, held button
    ballot_req = 1'b1; tick();
    chk("arm_state", 32'(state), 32'd1);
    chk("arm_ready", 32'(ballot_ready), 32'd1);
    ballot_req = 1'b0; vswitch = 3'b010; tick();
    chk("conf_state", 32'(state), 32'd2);
    chk("conf_vote_en", 32'(vote_en), 32'd0);
    tick();
    chk("rec_state", 32'(state), 32'd3);
    chk("rec_vote_en", 32'(vote_en), 32'd1);
    chk("rec_vote_sel", 32'(vote_sel), 32'b010);
    chk("rec_votes", 32'(votes_cast), 32'd1);
    chk("rec_ready", 32'(ballot_ready), 32'd0);
    tick();
    chk("rel_state", 32'(state), 32'd4);
    chk("rel_vote_sel", 32'(vote_sel), 32'd0);
    n_ev = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vote_en) n_ev++;
    end
    chk("held_no_revote", 32'(n_ev), 32'd0);
    chk("held_votes", 32'(votes_cast), 32'd1);
    vswitch = 3'b000; tick();
    chk("release_idle", 32'(state), 32'd0);

    // invalid press then valid vote
    ballot_req = 1'b1; tick();
    ballot_req = 1'b0; vswitch = 3'b011; tick();
    chk("inv_pulse", 32'(inv), 32'd1);
    chk("inv_state", 32'(state), 32'd1);
    vswitch = 3'b100; tick();
    chk("inv_clear", 32'(inv), 32'd0);
    chk("inv_conf", 32'(state), 32'd2);
    tick();
    chk("inv_rec_en", 32'(vote_en), 32'd1);
    chk("inv_rec_sel", 32'(vote_sel), 32'b100);
    chk("inv_votes", 32'(votes_cast), 32'd2);
    vswitch = 3'b000; tick(); tick();
    chk("inv_idle", 32'(state), 32'd0);

    // timeout
    ballot_req = 1'b1; tick();
    ballot_req = 1'b0;
    n_ev = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (timeout || vote_en || state != 3'd1) n_ev++;
    end
    chk("to_wait", 32'(n_ev), 32'd0);
    tick();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_state", 32'(state), 32'd0);
    chk("to_votes", 32'(votes_cast), 32'd2);
    tick();
    chk("to_pulse_end", 32'(timeout), 32'd0);

    // bounce back to ARMED
    ballot_req = 1'b1; tick();
    ballot_req = 1'b0; vswitch = 3'b001; tick();
    chk("bnc_conf", 32'(state), 32'd2);
    vswitch = 3'b000; tick();
    chk("bnc_state", 32'(state), 32'd1);
    chk("bnc_inv", 32'(inv), 32'd0);
    chk("bnc_vote_en", 32'(vote_en), 32'd0);

    // close during CONFIRM
    vswitch = 3'b001; tick();
    chk("cl_conf", 32'(state), 32'd2);
    poll_close = 1'b1; tick();
    poll_close = 1'b0;
    chk("cl_rec_en", 32'(vote_en), 32'd1);
    chk("cl_votes", 32'(votes_cast), 32'd3);
    chk("cl_not_yet", 32'(poll_closed), 32'd0);
    tick();
    chk("cl_rel", 32'(state), 32'd4);
    vswitch = 3'b000; tick();
    chk("cl_state", 32'(state), 32'd5);
    chk("cl_closed", 32'(poll_closed), 32'd1);
    ballot_req = 1'b1; tick(); tick();
    ballot_req = 1'b0;
    chk("cl_ignore", 32'(state), 32'd5);
    chk("cl_ignore_rdy", 32'(ballot_ready), 32'd0);

    // reset mid-ballot
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_closed", 32'(poll_closed), 32'd0);
    ballot_req = 1'b1; tick();
    ballot_req = 1'b0; vswitch = 3'b010; tick(); tick();
    chk("rst3_rec", 32'(state), 32'd3);
    rst = 1'b1; tick();
    rst = 1'b0; vswitch = 3'b000;
    chk("rst3_state", 32'(state), 32'd0);
    chk("rst3_votes", 32'(votes_cast), 32'd0);
    chk("rst3_vote_en", 32'(vote_en), 32'd0);

    // saturation
    for (int i = 0; i < 255; i++) one_ballot();
    chk("sat_255", 32'(votes_cast), 32'd255);
    chk("sat_idle", 32'(state), 32'd0);
    one_ballot();
    chk("sat_256", 32'(votes_cast), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ballot_controller.md
BALLOT_CONTROLLER -- requirements
Module: ballot_controller

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive identical samples required to accept a press; minimum value 1.
REQ-002 Parameter TIMEOUT, default 1000: clk cycles an armed ballot waits for a valid press.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 ballot_req  input  1  presiding-officer request to arm one ballot; sampled per edge.
REQ-006 poll_close  input  1  request to close the poll.
REQ-007 vswitch  input  3  voter candidate buttons, raw.
REQ-008 vote_en  output  1  one-cycle strobe to the vote-counter datapath.
REQ-009 vote_sel  output  3  one-hot candidate; valid only while vote_en=1, else 3'b000.
REQ-010 ballot_ready  output  1  voter lamp; high in ARMED and CONFIRM.
REQ-011 inv  output  1  one-cycle pulse on an invalid press.
REQ-012 timeout  output  1  one-cycle pulse when an armed ballot expires.
REQ-013 poll_closed  output  1  level; high in CLOSED.
REQ-014 votes_cast  output  8  total recorded votes.
REQ-015 state  output  3  encoding: IDLE=0, ARMED=1, CONFIRM=2, RECORD=3, RELEASE=4, CLOSED=5.

Function
REQ-016 IDLE: on ballot_req=1 with poll_close=0 and no pending close, go to ARMED and clear the timeout counter; otherwise stay in IDLE.
REQ-017 ARMED, vswitch=000: increment the timeout counter; when it reaches TIMEOUT-1, pulse timeout and go to IDLE.
REQ-018 ARMED, vswitch one-hot: latch vswitch as sel and set cnt=1; go to RECORD if DEBOUNCE=1, else to CONFIRM.
REQ-019 ARMED, vswitch with two or more bits set: pulse inv and stay in ARMED; the timeout counter keeps running.
REQ-020 CONFIRM, vswitch equal to sel: increment cnt; when cnt+1 equals DEBOUNCE, go to RECORD.
REQ-021 CONFIRM, vswitch=000: go to ARMED with no inv pulse (bounce).
REQ-022 CONFIRM, vswitch nonzero and different from sel: pulse inv and go to ARMED.
REQ-023 CONFIRM: the timeout counter is frozen.
REQ-024 RECORD lasts exactly one cycle: vote_en=1, vote_sel=sel, and votes_cast increments, saturating at 255; then go to RELEASE.
REQ-025 RELEASE: stay until vswitch=000, then go to IDLE; the held button can never produce a second vote.
REQ-026 ballot_req is ignored in every state except IDLE.
REQ-027 poll_close in IDLE goes to CLOSED and wins over a simultaneous ballot_req.
REQ-028 poll_close in any other state sets a pending-close flag; the transition that would enter IDLE enters CLOSED instead, so an in-progress ballot completes or expires first.
REQ-029 CLOSED is terminal until rst; all inputs are ignored there and vote_en stays 0.
REQ-030 All outputs are registered.
REQ-031 Latency: a one-hot press first sampled in ARMED at edge E gives vote_en high during the cycle after edge E+DEBOUNCE-1.

Reset
REQ-032 rst=1 at a posedge forces state=IDLE and clears vote_en, vote_sel, ballot_ready, inv, timeout, poll_closed, votes_cast, cnt, sel, the timeout counter and pending-close, in every state including mid-ballot.
REQ-033 rst has priority over all other inputs.

Verification (DEBOUNCE=2, TIMEOUT=8)
REQ-034 Reset, pulse ballot_req, hold vswitch=010 for 2 edges -> one vote_en pulse with vote_sel=010, votes_cast=1; vswitch held for 10 more cycles -> no further vote_en; release -> IDLE.
REQ-035 Armed ballot, vswitch=011 -> inv pulse for one cycle, state stays ARMED; then 100 for 2 edges -> vote_sel=100 recorded.
REQ-036 Armed ballot, no press for 8 cycles -> timeout pulse, state=IDLE, votes_cast unchanged, vote_en never asserted.
REQ-037 Armed ballot, vswitch=001 for 1 edge then 000 -> back to ARMED with no vote and no inv.
REQ-038 poll_close asserted during CONFIRM -> vote still recorded, then RELEASE; on release -> CLOSED with poll_closed=1; later ballot_req -> no effect.
REQ-039 Reset during RECORD/RELEASE -> next cycle state=IDLE, votes_cast=0; 256 successful ballots -> votes_cast stays 255.
